// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM states, the reset PC default and the buffered IF/ID entry.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_WAIT,
      ST_DRAIN,
      ST_HALT
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pcplus4;
   } fetch_entry_t;

   localparam fetch_entry_t ENTRY_RST = '{instr: NOP, pc: 32'h0, pcplus4: 32'h0};

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry IF/ID buffer: output register plus one skid entry, order preserving.
// A push lands in the output register next cycle; pop frees it, held words wait in the skid entry.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_dat,
   input  logic         pop,
   output logic         out_vld,
   output fetch_entry_t out_dat,
   output logic         full
);

   logic         sk_vld;
   fetch_entry_t sk_dat;
   logic         take;

   assign take = pop & out_vld;
   assign full = out_vld & sk_vld;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_vld <= 1'b0;
         sk_vld  <= 1'b0;
         out_dat <= ENTRY_RST;
         sk_dat  <= ENTRY_RST;
      end else if (flush) begin
         out_vld <= 1'b0;
         sk_vld  <= 1'b0;
      end else if (take) begin
         // the older skid word always moves up before any new arrival
         if (sk_vld) begin
            out_dat <= sk_dat;
            sk_vld  <= push;
            if (push) sk_dat <= push_dat;
         end else begin
            out_vld <= push;
            if (push) out_dat <= push_dat;
         end
      end else if (push) begin
         if (!out_vld) begin
            out_vld <= 1'b1;
            out_dat <= push_dat;
         end else begin
            sk_vld <= 1'b1;
            sk_dat <= push_dat;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, results on if_* one cycle after imem_ready.
// Requests only while the skid buffer has room; redirect flushes and drains, brk/cont halt and resume.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          IMEM_AW  = 32
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   input  logic               brk,
   input  logic               cont,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ready,
   input  logic [31:0]        imem_rdata,
   output logic               if_valid,
   output logic [31:0]        if_instr,
   output logic [31:0]        if_pc,
   output logic [31:0]        if_pcplus4,
   output logic               halted
);

   fetch_state_t state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  pend_pc_q, pend_pc_d;
   logic         drop_q, drop_d;
   logic         halt_pend_q, halt_pend_d;
   logic         req;
   logic [31:0]  req_pc;
   logic         push;
   logic         buf_full;
   fetch_entry_t push_dat;
   fetch_entry_t out_dat;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         fetch_pc_q  <= RESET_PC;
         pend_pc_q   <= RESET_PC;
         drop_q      <= 1'b0;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         pend_pc_q   <= pend_pc_d;
         drop_q      <= drop_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      pend_pc_d   = pend_pc_q;
      drop_d      = drop_q;
      halt_pend_d = halt_pend_q;
      req         = 1'b0;
      req_pc      = pend_pc_q;
      case (state_q)
         ST_RUN: begin
            req_pc = fetch_pc_q;
            if (brk) begin
               state_d = ST_HALT;
            end else if (!buf_full) begin
               req = 1'b1;
               if (!imem_ready) begin
                  pend_pc_d = fetch_pc_q;
                  drop_d    = redirect;
                  state_d   = redirect ? ST_DRAIN : ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            req         = 1'b1;
            halt_pend_d = halt_pend_q | brk;
            if (imem_ready) begin
               state_d     = (halt_pend_q | brk) ? ST_HALT : ST_RUN;
               halt_pend_d = 1'b0;
            end else if (redirect) begin
               state_d = ST_DRAIN;
               drop_d  = 1'b1;
            end
         end
         ST_DRAIN: begin
            req         = 1'b1;
            halt_pend_d = halt_pend_q | brk;
            if (imem_ready) begin
               state_d     = (halt_pend_q | brk) ? ST_HALT : ST_RUN;
               halt_pend_d = 1'b0;
               drop_d      = 1'b0;
            end
         end
         ST_HALT: begin
            if (cont && !brk) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase

      // a response coinciding with redirect belongs to the abandoned path
      push = req & imem_ready & ~drop_q & ~redirect;
      if (push)     fetch_pc_d = req_pc + 32'd4;
      if (redirect) fetch_pc_d = redirect_pc;
   end

   assign push_dat = '{instr: imem_rdata, pc: req_pc, pcplus4: req_pc + 32'd4};

   fetch_skid_buf u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect),
      .push     (push),
      .push_dat (push_dat),
      .pop      (~stall),
      .out_vld  (if_valid),
      .out_dat  (out_dat),
      .full     (buf_full)
   );

   assign imem_req   = req & rst_n;
   assign imem_addr  = req_pc[IMEM_AW-1:0];
   assign if_instr   = out_dat.instr;
   assign if_pc      = out_dat.pc;
   assign if_pcplus4 = out_dat.pcplus4;
   assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-level model of the fetch stream.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, redirect, brk, cont;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_ready;
   logic [31:0] imem_addr, imem_rdata;
   logic        if_valid, halted;
   logic [31:0] if_instr, if_pc, if_pcplus4;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .brk         (brk),
      .cont        (cont),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .if_pcplus4  (if_pcplus4),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: buffered words as queues, fetch pc, one outstanding request, halt mode.
   logic [31:0] m_pc[$];
   logic [31:0] m_in[$];
   logic [31:0] m_fpc    = 32'h0;
   logic [31:0] m_o_addr = 32'h0;
   bit          m_o_vld  = 1'b0;
   bit          m_o_drop = 1'b0;
   bit          m_halted = 1'b0;
   bit          m_hpend  = 1'b0;

   always @(negedge clk) begin
      bit          e_vld, e_req, resp, was_h;
      logic [31:0] e_addr;
      if (chk_en) begin
         e_vld  = (m_pc.size() > 0);
         e_req  = rst_n && !m_halted &&
                  (m_o_vld || (!brk && !m_hpend && m_pc.size() < 2));
         e_addr = m_o_vld ? m_o_addr : m_fpc;
         cmp("if_valid", {31'b0, if_valid}, {31'b0, e_vld});
         cmp("halted", {31'b0, halted}, {31'b0, m_halted});
         cmp("imem_req", {31'b0, imem_req}, {31'b0, e_req});
         if (e_req) cmp("imem_addr", imem_addr, e_addr);
         if (e_vld) begin
            cmp("if_pc", if_pc, m_pc[0]);
            cmp("if_instr", if_instr, m_in[0]);
            cmp("if_pcplus4", if_pcplus4, m_pc[0] + 32'd4);
         end
         if (!rst_n) begin
            m_pc.delete();
            m_in.delete();
            m_fpc    = 32'h0;
            m_o_vld  = 1'b0;
            m_o_drop = 1'b0;
            m_halted = 1'b0;
            m_hpend  = 1'b0;
         end else begin
            resp  = e_req && imem_ready;
            was_h = m_halted;
            if (redirect) begin
               m_pc.delete();
               m_in.delete();
               m_fpc = redirect_pc;
            end else begin
               if (e_vld && !stall) begin
                  void'(m_pc.pop_front());
                  void'(m_in.pop_front());
               end
               if (resp && !m_o_drop) begin
                  m_pc.push_back(e_addr);
                  m_in.push_back(imem_rdata);
                  m_fpc = e_addr + 32'd4;
               end
            end
            if (resp) begin
               m_o_vld  = 1'b0;
               m_o_drop = 1'b0;
            end else if (e_req) begin
               m_o_vld  = 1'b1;
               m_o_addr = e_addr;
               m_o_drop = m_o_drop | redirect;
            end
            if (was_h) begin
               if (cont && !brk) m_halted = 1'b0;
            end else begin
               if (brk) m_hpend = 1'b1;
               if (m_hpend && !m_o_vld) begin
                  m_halted = 1'b1;
                  m_hpend  = 1'b0;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
      brk        = 1'b0;
      cont       = 1'b0;
      redirect   = 1'b0;
      imem_rdata = $urandom;
   endtask

   initial begin
      logic [31:0] r;
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      brk = 1'b0; cont = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;

      step;
      chk_en = 1'b1;
      @(negedge clk);
      cmp("rst_if_valid", {31'b0, if_valid}, 32'd0);
      cmp("rst_if_instr", if_instr, 32'd0);
      cmp("rst_if_pc", if_pc, 32'd0);
      cmp("rst_if_pcplus4", if_pcplus4, 32'd0);
      cmp("rst_halted", {31'b0, halted}, 32'd0);
      cmp("rst_imem_req", {31'b0, imem_req}, 32'd0);

      // sequential stream
      imem_ready = 1'b1;
      step; rst_n = 1'b1;
      @(negedge clk); cmp("seq_first_invalid", {31'b0, if_valid}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         step;
         @(negedge clk);
         cmp("seq_valid", {31'b0, if_valid}, 32'd1);
         cmp("seq_pc", if_pc, 32'(4 * k));
      end

      // memory wait at 0x8
      step; rst_n = 1'b0; imem_ready = 1'b1;
      step; rst_n = 1'b1;
      step;
      repeat (3) begin
         step; imem_ready = 1'b0;
         @(negedge clk);
         cmp("wait_req", {31'b0, imem_req}, 32'd1);
         cmp("wait_addr", imem_addr, 32'h8);
      end
      step; imem_ready = 1'b1;
      @(negedge clk); cmp("wait_ready_addr", imem_addr, 32'h8);
      step;
      @(negedge clk); cmp("wait_pc", if_pc, 32'h8);

      // stall for four cycles
      step; stall = 1'b1;
      @(negedge clk); cmp("stall_pc", if_pc, 32'hC);
      repeat (3) begin
         step;
         @(negedge clk);
         cmp("stall_hold_pc", if_pc, 32'hC);
         cmp("stall_full_noreq", {31'b0, imem_req}, 32'd0);
      end
      step; stall = 1'b0;
      @(negedge clk); cmp("release_pc0", if_pc, 32'hC);
      step; @(negedge clk); cmp("release_pc1", if_pc, 32'h10);
      step; @(negedge clk); cmp("release_pc2", if_pc, 32'h14);

      // redirect while waiting at 0x20
      step; rst_n = 1'b0; imem_ready = 1'b1;
      step; rst_n = 1'b1;
      repeat (7) step;
      step; imem_ready = 1'b0;
      @(negedge clk); cmp("redir_wait_addr", imem_addr, 32'h20);
      step; redirect = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      cmp("redir_req", {31'b0, imem_req}, 32'd1);
      cmp("redir_addr_held", imem_addr, 32'h20);
      step; imem_ready = 1'b1;
      @(negedge clk);
      cmp("drain_flushed", {31'b0, if_valid}, 32'd0);
      cmp("drain_addr", imem_addr, 32'h20);
      step;
      @(negedge clk);
      cmp("drain_dropped", {31'b0, if_valid}, 32'd0);
      cmp("redir_new_addr", imem_addr, 32'h100);
      step;
      @(negedge clk);
      cmp("redir_valid", {31'b0, if_valid}, 32'd1);
      cmp("redir_pc", if_pc, 32'h100);

      // brk, then cont five cycles later
      step; brk = 1'b1;
      @(negedge clk);
      cmp("brk_noreq", {31'b0, imem_req}, 32'd0);
      cmp("brk_pc", if_pc, 32'h104);
      repeat (4) begin
         step;
         @(negedge clk);
         cmp("halt_flag", {31'b0, halted}, 32'd1);
         cmp("halt_noreq", {31'b0, imem_req}, 32'd0);
      end
      step; cont = 1'b1;
      @(negedge clk); cmp("cont_cycle_halted", {31'b0, halted}, 32'd1);
      step;
      @(negedge clk);
      cmp("resume_halted", {31'b0, halted}, 32'd0);
      cmp("resume_req", {31'b0, imem_req}, 32'd1);
      cmp("resume_addr", imem_addr, 32'h108);

      // redirect with stall, brk with cont
      step; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
      @(negedge clk); cmp("rs_pc", if_pc, 32'h108);
      step; stall = 1'b0;
      @(negedge clk);
      cmp("rs_flushed", {31'b0, if_valid}, 32'd0);
      cmp("rs_addr", imem_addr, 32'h200);
      step; brk = 1'b1; cont = 1'b1;
      @(negedge clk); cmp("bc_pc", if_pc, 32'h200);
      step; brk = 1'b1; cont = 1'b1;
      @(negedge clk); cmp("bc_halted", {31'b0, halted}, 32'd1);
      step; cont = 1'b1;
      @(negedge clk); cmp("bc_still_halted", {31'b0, halted}, 32'd1);
      step;
      @(negedge clk);
      cmp("bc_resumed", {31'b0, halted}, 32'd0);
      cmp("bc_addr", imem_addr, 32'h204);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         step;
         stall      = ($urandom_range(0, 99) < 30);
         imem_ready = ($urandom_range(0, 99) < 65);
         redirect   = ($urandom_range(0, 99) < 3);
         r = $urandom;
         redirect_pc = r & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF4;
         brk   = ($urandom_range(0, 99) < 2);
         cont  = ($urandom_range(0, 99) < 12);
         rst_n = ($urandom_range(0, 999) != 0);
      end
      step;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter IMEM_AW, default 32, is the instruction-memory address width.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 stall  in  1  hazard-unit stall; the decode stage does not accept if_* this cycle.
REQ-006 redirect  in  1  branch/jump taken; fetch restarts at redirect_pc.
REQ-007 redirect_pc  in  32  target address, word aligned.
REQ-008 brk  in  1  single-cycle pulse requesting a halt.
REQ-009 cont  in  1  single-cycle pulse resuming from a halt.
REQ-010 imem_req  out  1  fetch request to instruction memory.
REQ-011 imem_addr  out  IMEM_AW  fetch address, stable while imem_req=1 and imem_ready=0.
REQ-012 imem_ready  in  1  request accepted; imem_rdata is valid in the same cycle.
REQ-013 imem_rdata  in  32  fetched instruction word.
REQ-014 if_valid  out  1  if_instr/if_pc/if_pcplus4 hold a valid instruction for IF/ID.
REQ-015 if_instr, if_pc, if_pcplus4  out  32 each  instruction word, its address, and its address + 4.
REQ-016 halted  out  1  high while in state HALT.

Function
REQ-017 The FSM has states RUN, WAIT, DRAIN and HALT; at most one memory request is outstanding.
REQ-018 In RUN, imem_req=1 with imem_addr=fetch_pc when the two-entry buffer has a free slot.
- imem_ready=1 in the same cycle: the word is captured and fetch_pc += 4.
- imem_ready=0: transition to WAIT.
REQ-019 In WAIT, imem_req and imem_addr are held until imem_ready=1; then capture, fetch_pc += 4, return to RUN.
REQ-020 Buffer: an output register plus one skid entry.
- A word is consumed when if_valid=1 and stall=0.
- A response that arrives while the output register is held under stall goes to the skid entry.
- No request is issued while both entries are full.
REQ-021 Order is preserved: skid-entry contents move to the output register on the first consume cycle.
REQ-022 redirect=1, in any state other than reset:
- both buffer entries are invalidated, so if_valid=0 next cycle;
- fetch_pc := redirect_pc;
- an outstanding request's response is discarded through a drop flag and the FSM goes to DRAIN.
REQ-023 In DRAIN, the FSM waits for imem_ready without capturing the data, then goes to RUN.
REQ-024 redirect has priority over stall in the same cycle.
REQ-025 brk: issue no new requests, complete any outstanding request (capturing it), then enter HALT; the buffer keeps draining under stall rules.
REQ-026 In HALT: imem_req=0 and halted=1.
- cont returns the FSM to RUN at fetch_pc.
- redirect in HALT updates fetch_pc and flushes the buffer; the FSM stays in HALT.
REQ-027 brk and cont asserted in the same cycle: cont is ignored and brk is taken.
REQ-028 fetch_pc wraps modulo 2^32; if_pcplus4 = if_pc + 4, also modulo 2^32.
REQ-029 Best-case latency: an instruction appears on if_* one cycle after the imem_ready cycle.
REQ-030 Sustained throughput is one instruction per cycle when imem_ready is always 1 and stall=0.

Reset
REQ-031 With rst_n=0 at a clock edge:
- FSM := RUN; fetch_pc := RESET_PC;
- both buffer entries invalid; drop flag cleared;
- outputs if_valid=0, if_instr=0, if_pc=0, if_pcplus4=0, halted=0, imem_req=0.
REQ-032 Reset in the middle of WAIT or DRAIN abandons the outstanding request; the first request after reset is at RESET_PC.

Structure
REQ-033 The package fetch_pkg holds the FSM state enum, the RESET_PC default and the NOP constant 32'h0000_0000.
REQ-034 The two-entry buffer is a sub-module, fetch_skid_buf, with push/pop/flush ports.

Verification
REQ-035 Reset, then imem_ready tied to 1 and stall=0: if_pc = 0, 4, 8, 12 on consecutive cycles, with if_valid=1 from the second cycle onward.
REQ-036 imem_ready low for 3 cycles at address 0x8: imem_addr holds 0x8 and imem_req stays high; if_pc=0x8 appears one cycle after ready.
REQ-037 stall held for 4 cycles: if_* stays constant; at most two words are buffered; after release, if_pc continues sequentially with no gap or duplicate.
REQ-038 redirect to 0x100 while WAIT is pending at 0x20: the 0x20 word never appears on if_*; the next valid if_pc is 0x100.
REQ-039 brk pulse, then cont 5 cycles later: halted=1 and imem_req=0 during the halt; fetch resumes at the next sequential PC.
REQ-040 redirect and stall asserted in the same cycle, and brk and cont asserted in the same cycle: the FSM behaves as REQ-024 and REQ-027 specify.
